arilla_bus_arbiter: RTL
=======================

# arilla_bus_arbiter

Two-requester arbiter that shares one arilla bus slave port (system memory) between the hart's `rv_core` bus master (requester 0) and the debug module's system-bus-access master (requester 1). The active owner's request is routed to the slave. The non-owner is held off with `inhibit`. Ownership is parked on the last owner, so an uncontended requester pays no arbitration latency. A bounded lock gives the debug module atomic multi-access sequences without starving the core.

## Interface
- `DataWidth`, 32: data bus width in bits.
- `ByteAddressWidth`, 32: byte address width.
- `ByteSize`, 8: bits per byte lane; `BeWidth = DataWidth/ByteSize`.
- `MaxHold`, 4: maximum consecutive completed transactions one owner may keep while the other waits. Legal range 1..15.
- `clk` in 1: the single clock; everything is on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `mN_addr` in ByteAddressWidth: requester N address, N∈{0,1}.
- `mN_rd` / `mN_wr` in 1 each: requester N read / write strobe. Never both high.
- `mN_be` in BeWidth: requester N byte enables.
- `mN_wdata` in DataWidth: requester N write data.
- `mN_lock` in 1: requester N asks to keep ownership after the current transaction.
- `mN_rdata` out DataWidth: `s_rdata` broadcast to both requesters.
- `mN_inhibit` out 1: requester N stalled.
- `mN_intercept` out 1: slave intercept forwarded to requester N.
- `s_addr`, `s_rd`, `s_wr`, `s_be`, `s_wdata` out: muxed request to the slave.
- `s_rdata` in DataWidth: slave read data.
- `s_inhibit` in 1: slave stall.
- `s_intercept` in 1: slave intercept.

## Operation
- `reqN = mN_rd | mN_wr`. A transaction by owner N completes in a cycle where `reqN=1` and `s_inhibit=0`.
- State: `owner` (1 bit, states OWN0/OWN1) and `hold_cnt` (4 bits, saturating at MaxHold).
- Slave outputs are driven combinationally from the owner's request signals at all times.
- Inhibit and intercept:
  - Owner: `mN_inhibit = s_inhibit`, `mN_intercept = s_intercept`.
  - Non-owner: `mN_inhibit = 1`, `mN_intercept = 0`.
- Handover condition, evaluated in OWNx with other requester y:
  - `reqx=0` and `reqy=1` → switch to OWNy next cycle.
  - Completion by x, `reqy=1`, and (`mx_lock=0` or `hold_cnt+1 >= MaxHold`) → switch to OWNy next cycle.
  - Otherwise stay in OWNx.
- A transaction in progress (`reqx=1`, `s_inhibit=1`) is never preempted.
- `hold_cnt` rules:
  - Cleared on every switch.
  - Cleared while `reqy=0`.
  - Otherwise incremented on each completion by the owner.
- `mx_lock` with the other requester idle has no effect; ownership stays parked.
- Simultaneous requests from OWN0 parked with `req0=0`: requester 1 wins, because the parked owner is not requesting.

## Timing
- Reset, synchronous on `rst_n=0`:
  - `owner=0`, `hold_cnt=0`.
  - Slave outputs mirror requester 0.
  - `m1_inhibit=1`, `m1_intercept=0`.
  - `m0_inhibit = s_inhibit`, `m0_intercept = s_intercept`.
- Reset mid-transaction abandons requester 1 ownership immediately. The slave sees requester 0's signals in the cycle after the reset edge.
- Latency:
  - Owner request: 0 cycles added; combinational pass-through.
  - Non-owner: at least 1 inhibited cycle (the switch cycle), then it sees slave timing.
- Worst-case wait for a non-owner: MaxHold transactions of the owner, each with its own slave stall.
- Requesters must hold address, strobes, data and lock stable while their `inhibit=1`.

## Structure
- Shared package `arilla_arb_pkg` holds:
  - the `owner_e` enum: OWN0 = 1'b0, OWN1 = 1'b1;
  - the reset owner constant `ARB_RESET_OWNER = OWN0`.
- One natural sub-module, `arilla_arb_ctrl`: owner FSM plus hold counter, with inputs `req0/1`, `lock0/1`, `s_inhibit` and output `owner`. The top level is the mux and inhibit/intercept steering.
- The `DataWidth`/`ByteAddressWidth`/`ByteSize` defaults come from the existing `SYSTEM__XLEN`/`ALEN`/`BLEN` defines at instantiation.

## Test plan
- **Reset parking:** reset released, only `m0_rd=1` at addr 0x100 with `s_inhibit=0` → `s_addr=0x100` the same cycle, `m0_inhibit=0`, `m1_inhibit=1`.
- **Contention with parked idle owner:** OWN0, `req0=0`, `m1_wr=1`, addr 0x200 → cycle 1 `m1_inhibit=1`; cycle 2 `s_wr=1`, `s_addr=0x200`, `m1_inhibit=0`.
- **No preemption:** owner 0 read stalled by `s_inhibit=1` for 3 cycles while `m1_rd=1` → owner stays 0 for those 3 cycles plus the completion cycle, then switches to 1.
- **Bounded lock:** MaxHold=4, owner 1 with `m1_lock=1` issues back-to-back writes, core requesting throughout → exactly 4 completions by requester 1, then owner 0 for the next cycle.
- **Lock without contention:** `m1_lock=1`, `req0=0`, 10 writes → all complete, `hold_cnt` stays 0, no switch.
- **Reset mid-operation:** `rst_n=0` while owner 1 is stalled → next cycle owner 0, `m1_inhibit=1`, slave outputs equal requester 0's signals.

Source files
------------

// File: rtl/arilla_arb_pkg.sv
// Shared types for the arilla bus arbiter: owner encoding and reset owner.
package arilla_arb_pkg;

    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } owner_e;

    localparam owner_e ARB_RESET_OWNER = OWN0;

endpackage

// File: rtl/arilla_arb_ctrl.sv
// Owner FSM with hold counter: parks on the last owner and bounds how long a
// locking owner may keep the bus while the other requester waits.
module arilla_arb_ctrl
    import arilla_arb_pkg::*;
#(
    parameter int MaxHold = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req0,
    input  logic   req1,
    input  logic   lock0,
    input  logic   lock1,
    input  logic   s_inhibit,
    output owner_e owner
);

    owner_e     owner_reg;
    logic [3:0] hold_cnt_reg;

    logic       req_own;
    logic       req_oth;
    logic       lock_own;
    logic       complete;
    logic [4:0] hold_inc;
    logic       at_limit;
    logic       switch_now;

    always_comb begin
        req_own  = (owner_reg == OWN1) ? req1  : req0;
        req_oth  = (owner_reg == OWN1) ? req0  : req1;
        lock_own = (owner_reg == OWN1) ? lock1 : lock0;
        complete = req_own & ~s_inhibit;
        hold_inc = {1'b0, hold_cnt_reg} + 5'd1;
        at_limit = (hold_inc >= 5'(MaxHold));
        // A stalled owner transaction (req_own & s_inhibit) never satisfies this.
        switch_now = req_oth & (~req_own | (complete & (~lock_own | at_limit)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_reg    <= ARB_RESET_OWNER;
            hold_cnt_reg <= 4'd0;
        end else if (switch_now) begin
            owner_reg    <= (owner_reg == OWN1) ? OWN0 : OWN1;
            hold_cnt_reg <= 4'd0;
        end else if (!req_oth) begin
            hold_cnt_reg <= 4'd0;
        end else if (complete) begin
            hold_cnt_reg <= at_limit ? 4'(MaxHold) : hold_inc[3:0];
        end
    end

    assign owner = owner_reg;

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Two-requester arilla bus arbiter: routes the owner's request to the slave
// and steers inhibit/intercept. Width defaults track SYSTEM__XLEN/ALEN/BLEN.
module arilla_bus_arbiter
    import arilla_arb_pkg::*;
#(
    parameter int DataWidth        = 32,
    parameter int ByteAddressWidth = 32,
    parameter int ByteSize         = 8,
    parameter int MaxHold          = 4,
    localparam int BeWidth         = DataWidth / ByteSize
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [ByteAddressWidth-1:0] m0_addr,
    input  logic                        m0_rd,
    input  logic                        m0_wr,
    input  logic [BeWidth-1:0]          m0_be,
    input  logic [DataWidth-1:0]        m0_wdata,
    input  logic                        m0_lock,
    output logic [DataWidth-1:0]        m0_rdata,
    output logic                        m0_inhibit,
    output logic                        m0_intercept,

    input  logic [ByteAddressWidth-1:0] m1_addr,
    input  logic                        m1_rd,
    input  logic                        m1_wr,
    input  logic [BeWidth-1:0]          m1_be,
    input  logic [DataWidth-1:0]        m1_wdata,
    input  logic                        m1_lock,
    output logic [DataWidth-1:0]        m1_rdata,
    output logic                        m1_inhibit,
    output logic                        m1_intercept,

    output logic [ByteAddressWidth-1:0] s_addr,
    output logic                        s_rd,
    output logic                        s_wr,
    output logic [BeWidth-1:0]          s_be,
    output logic [DataWidth-1:0]        s_wdata,
    input  logic [DataWidth-1:0]        s_rdata,
    input  logic                        s_inhibit,
    input  logic                        s_intercept
);

    if (MaxHold < 1 || MaxHold > 15) begin : g_bad_max_hold
        $error("arilla_bus_arbiter: MaxHold must be in 1..15");
    end

    owner_e     owner;
    logic [1:0] inhibit_vec;
    logic [1:0] intercept_vec;

    arilla_arb_ctrl #(
        .MaxHold (MaxHold)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (m0_rd | m0_wr),
        .req1      (m1_rd | m1_wr),
        .lock0     (m0_lock),
        .lock1     (m1_lock),
        .s_inhibit (s_inhibit),
        .owner     (owner)
    );

    always_comb begin
        if (owner == OWN1) begin
            s_addr  = m1_addr;
            s_rd    = m1_rd;
            s_wr    = m1_wr;
            s_be    = m1_be;
            s_wdata = m1_wdata;
        end else begin
            s_addr  = m0_addr;
            s_rd    = m0_rd;
            s_wr    = m0_wr;
            s_be    = m0_be;
            s_wdata = m0_wdata;
        end
    end

    // Non-owner is held off and never sees the slave's intercept.
    for (genvar gi = 0; gi < 2; gi++) begin : g_steer
        assign inhibit_vec[gi]   = (owner == owner_e'(1'(gi))) ? s_inhibit   : 1'b1;
        assign intercept_vec[gi] = (owner == owner_e'(1'(gi))) ? s_intercept : 1'b0;
    end

    assign m0_inhibit   = inhibit_vec[0];
    assign m1_inhibit   = inhibit_vec[1];
    assign m0_intercept = intercept_vec[0];
    assign m1_intercept = intercept_vec[1];
    assign m0_rdata     = s_rdata;
    assign m1_rdata     = s_rdata;

endmodule
